mem_port_arbiter: RTL

Shares the single-port synchronous memory (30-bit word address, 32-bit data, one-cycle registered read) between two requesters: the CPU instruction-fetch port (read-only) and the load/store data port (read/write). A three-state FSM serialises accesses. Arbitration is round-robin by default, or fixed data-first. The block sits between the CPU core and the memory inside master, replacing direct pc-to-memory wiring.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port synchronous memory (one-cycle
//                registered read) between the CPU instruction-fetch port
//                (read-only) and the load/store data port (read/write).
//                A three-state FSM (IDLE -> ACCESS -> RESP) serialises
//                accesses; ties are broken round-robin or data-first.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                if_req/if_addr        - fetch request and word address
//                if_rdata/if_done      - fetch read data and completion pulse
//                d_req/d_we/d_addr/
//                d_wdata               - data request, direction, addr, wdata
//                d_rdata/d_done        - data read result and completion pulse
//                mem_addr/mem_wdata/
//                mem_wr_en/mem_rdata   - memory-side interface
//                busy                  - high whenever the FSM is not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 30,
    parameter int DATA_W     = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic c_OWNER_FETCH = 1'b0;
    localparam logic c_OWNER_DATA  = 1'b1;

    state_t              state_q,      state_d;
    logic                owner_q,      owner_d;
    logic                last_owner_q, last_owner_d;
    logic                we_q,         we_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q,  mem_wdata_d;
    logic                mem_wr_en_q,  mem_wr_en_d;
    logic [DATA_W-1:0]   if_hold_q,    if_hold_d;
    logic [DATA_W-1:0]   d_hold_q,     d_hold_d;

    logic                w_winner;

    // Winner among the requests present this cycle. On a tie the round-robin
    // mode hands the grant to whichever port was not served last.
    always_comb begin
        w_winner = c_OWNER_FETCH;
        if (if_req && d_req) begin
            if (FIXED_PRIO) begin
                w_winner = c_OWNER_DATA;
            end else begin
                w_winner = (last_owner_q == c_OWNER_DATA) ? c_OWNER_FETCH : c_OWNER_DATA;
            end
        end else if (d_req) begin
            w_winner = c_OWNER_DATA;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wr_en_d  = mem_wr_en_q;
        if_hold_d    = if_hold_q;
        d_hold_d     = d_hold_q;

        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    state_d      = S_ACCESS;
                    owner_d      = w_winner;
                    last_owner_d = w_winner;
                    if (w_winner == c_OWNER_DATA) begin
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wr_en_d = d_we;
                        we_d        = d_we;
                    end else begin
                        // Fetches never write; mem_wdata keeps its old value.
                        mem_addr_d  = if_addr;
                        mem_wr_en_d = 1'b0;
                        we_d        = 1'b0;
                    end
                end
            end
            S_ACCESS: begin
                // Memory samples the request at this edge; write strobe ends.
                state_d     = S_RESP;
                mem_wr_en_d = 1'b0;
            end
            S_RESP: begin
                state_d = S_IDLE;
                // Capture read data so rdata stays stable after the done pulse.
                if (owner_q == c_OWNER_FETCH) begin
                    if_hold_d = mem_rdata;
                end else if (!we_q) begin
                    d_hold_d = mem_rdata;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= c_OWNER_FETCH;
            last_owner_q <= c_OWNER_DATA;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wr_en_q  <= 1'b0;
            if_hold_q    <= '0;
            d_hold_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wr_en_q  <= mem_wr_en_d;
            if_hold_q    <= if_hold_d;
            d_hold_q     <= d_hold_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign if_done   = (state_q == S_RESP) && (owner_q == c_OWNER_FETCH);
    assign d_done    = (state_q == S_RESP) && (owner_q == c_OWNER_DATA);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr_en = mem_wr_en_q;

    // During RESP a read passes memory data straight through; writes leave
    // d_rdata showing the last read result.
    assign if_rdata  = if_done ? mem_rdata : if_hold_q;
    assign d_rdata   = (d_done && !we_q) ? mem_rdata : d_hold_q;

endmodule
`default_nettype wire
